// File: rtl/mandel_coord_sequencer.sv
// Raster-order complex coordinate generator for the Mandelbrot pixel pipeline.
// Streams one (re, im) pair per pixel with SOF/EOL/EOF tags over valid/ready.
module mandel_coord_sequencer #(
    parameter int X_SIZE  = 1024,
    parameter int Y_SIZE  = 768,
    parameter int COORD_W = 32
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               cfg_wr_en,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic [2:0]         cfg_rd_addr,
    output logic [31:0]        cfg_rdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [COORD_W-1:0] m_re,
    output logic [COORD_W-1:0] m_im,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic               busy,
    output logic               frame_done
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t state, state_nxt;

    logic        run, cont, abort_pending;
    logic [31:0] re_origin, im_origin, step, frame_cnt;
    logic [31:0] rd_mux;

    logic signed [COORD_W-1:0] sh_re, sh_step, re_acc, im_acc;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic accept, last_x, last_y, abort_fire;

    // Software registers are 32 bits wide; the datapath uses the low COORD_W bits (COORD_W <= 32).
    function automatic logic signed [COORD_W-1:0] to_coord(input logic [31:0] v);
        return $signed(v[COORD_W-1:0]);
    endfunction

    assign accept     = (state == STREAM) && m_tready;
    assign last_x     = (x == XW'(X_SIZE - 1));
    assign last_y     = (y == YW'(Y_SIZE - 1));
    // In STREAM the abort must wait for the beat on the bus to be taken.
    assign abort_fire = abort_pending && ((state != STREAM) || accept);

    assign m_tvalid   = (state == STREAM);
    assign m_re       = re_acc;
    assign m_im       = im_acc;
    assign m_sof      = m_tvalid && (x == '0) && (y == '0);
    assign m_eol      = m_tvalid && last_x;
    assign m_eof      = m_tvalid && last_x && last_y;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!abort_pending && run) state_nxt = LOAD;
            LOAD:   state_nxt = abort_fire ? IDLE : STREAM;
            STREAM: begin
                if (abort_fire)                  state_nxt = IDLE;
                else if (accept && last_x && last_y) state_nxt = DONE;
            end
            DONE:   state_nxt = (!abort_pending && cont && run) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; a software write in the same cycle overrides FSM updates.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run           <= 1'b0;
            cont          <= 1'b0;
            abort_pending <= 1'b0;
            re_origin     <= '0;
            im_origin     <= '0;
            step          <= '0;
            frame_cnt     <= '0;
        end else begin
            if (abort_fire) begin
                abort_pending <= 1'b0;
                run           <= 1'b0;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 32'd1;
                if (state_nxt == IDLE) run <= 1'b0;
            end
            if (cfg_wr_en) begin
                case (cfg_addr)
                    3'd0: begin
                        run  <= cfg_wdata[0] && !cfg_wdata[2];
                        cont <= cfg_wdata[1];
                        if (cfg_wdata[2]) abort_pending <= 1'b1;
                    end
                    3'd1: re_origin <= cfg_wdata;
                    3'd2: im_origin <= cfg_wdata;
                    3'd3: step      <= cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Coordinate accumulators: re steps along the line, im steps down per line, both wrapping.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sh_re   <= '0;
            sh_step <= '0;
            re_acc  <= '0;
            im_acc  <= '0;
            x       <= '0;
            y       <= '0;
        end else if (state == LOAD) begin
            sh_re   <= to_coord(re_origin);
            sh_step <= to_coord(step);
            re_acc  <= to_coord(re_origin);
            im_acc  <= to_coord(im_origin);
            x       <= '0;
            y       <= '0;
        end else if (accept) begin
            if (last_x) begin
                x      <= '0;
                y      <= last_y ? '0 : y + 1'b1;
                re_acc <= sh_re;
                im_acc <= im_acc - sh_step;
            end else begin
                x      <= x + 1'b1;
                re_acc <= re_acc + sh_step;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cfg_rd_addr)
            3'd0: rd_mux = {30'd0, cont, run};
            3'd1: rd_mux = re_origin;
            3'd2: rd_mux = im_origin;
            3'd3: rd_mux = step;
            3'd4: rd_mux = {30'd0, abort_pending, busy};
            3'd5: rd_mux = frame_cnt;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) cfg_rdata <= '0;
        else        cfg_rdata <= rd_mux;
    end

endmodule
